// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port data RAM.
// Each access is IDLE -> ACCESS (one RAM cycle) -> DONE (ack pulse) -> IDLE.
module ram_port_arbiter #(
  parameter int MEM_DEPTH = 1024,
  parameter int SIZE      = 32,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [SIZE-1:0]   wdata0,
  input  logic [SIZE-1:0]   wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [SIZE-1:0]   rdata0,
  output logic [SIZE-1:0]   rdata1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [SIZE-1:0]   ram_data,
  output logic              ram_wren,
  output logic              ram_wread,
  input  logic [SIZE-1:0]   ram_salida,
  output logic              busy,
  output logic              grant,
  output logic [1:0]        state_dbg
);

  // Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds
  // them until ackN pulses; reqN must be low by the edge closing the ack cycle,
  // otherwise the next IDLE sees it as a fresh access.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state;
  logic                last_grant;
  logic                win_valid;
  logic                winner;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [SIZE-1:0]     sel_wdata;

  assign state_dbg = state;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    win_valid = req0 | req1;
    winner    = 1'b0;
    if (req0 && req1)
      winner = ~last_grant;
    else if (req1)
      winner = 1'b1;
    sel_we    = winner ? we1    : we0;
    sel_addr  = winner ? addr1  : addr0;
    sel_wdata = winner ? wdata1 : wdata0;
  end

  // The ram_* registers double as the latched request, so reset clears both.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      busy        <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      ram_wread   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (win_valid) begin
            state       <= ACCESS;
            grant       <= winner;
            last_grant  <= winner;
            busy        <= 1'b1;
            ram_address <= sel_addr;
            ram_wren    <= sel_we;
            ram_wread   <= ~sel_we;
            ram_data    <= sel_we ? sel_wdata : '0;
          end
        end
        ACCESS: begin
          state <= DONE;
          if (ram_wread) begin
            if (grant)
              rdata1 <= ram_salida;
            else
              rdata0 <= ram_salida;
          end
          ram_address <= '0;
          ram_data    <= '0;
          ram_wren    <= 1'b0;
          ram_wread   <= 1'b0;
          ack0        <= ~grant;
          ack1        <= grant;
        end
        DONE: begin
          state <= IDLE;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, reference memory plus
// round-robin rule, protocol monitor, and scripted random scenarios.
module tb_ram_port_arbiter;

  logic        clock;
  logic        reset_n;
  logic        req0, req1, we0, we1;
  logic [9:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [9:0]  ram_address;
  logic [31:0] ram_data;
  logic        ram_wren, ram_wread;
  logic [31:0] ram_salida;
  logic        busy, grant;
  logic [1:0]  state_dbg;

  ram_port_arbiter #(.MEM_DEPTH(1024), .SIZE(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_wread(ram_wread), .ram_salida(ram_salida),
    .busy(busy), .grant(grant), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- RAM environment ----------------
  logic [31:0] mem [0:1023];
  assign ram_salida = ram_wread ? mem[ram_address] : 32'd0;
  always @(posedge clock) if (ram_wren) mem[ram_address] <= ram_data;

  // ---------------- reference model state ----------------
  logic [31:0] ref_mem [0:1023];
  logic        model_last;
  logic [31:0] exp_q[$];
  logic        grant_log[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- protocol monitor ----------------
  int   cyc = 0, last_ack_cyc = 0, ack_cnt = 0;
  int   proto_viol = 0, en_viol = 0, gap_viol = 0, wren_cycles = 0;
  logic prev_ack0 = 0, prev_ack1 = 0, prev_en = 0;

  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      prev_ack0 = 0; prev_ack1 = 0; prev_en = 0;
    end else begin
      if ((prev_ack0 && req0) || (prev_ack1 && req1)) proto_viol++;
      if (ram_wren && ram_wread) en_viol++;
      if ((ram_wren || ram_wread) && (!busy || ack0 || ack1 || prev_en)) en_viol++;
      if (ack0 && ack1) en_viol++;
      if (ram_wren) wren_cycles++;
      if (ack0 || ack1) begin
        if (ack_cnt > 0 && (cyc - last_ack_cyc) < 3) gap_viol++;
        ack_cnt++;
        last_ack_cyc = cyc;
        grant_log.push_back(grant);
      end
      prev_ack0 = ack0; prev_ack1 = ack1; prev_en = ram_wren | ram_wread;
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns two negedges after the ack so req is low
  // across the following IDLE.
  task automatic req_port(input bit p, input logic w, input logic [9:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output int lat);
    lat = 0;
    if (!p) begin we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else    begin we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
    do begin
      @(negedge clock);
      lat++;
    end while (!(p ? ack1 : ack0) && lat < 20);
    if (!(p ? ack1 : ack0)) lat = 99;
    rd = p ? rdata1 : rdata0;
    if (!p) req0 = 1'b0; else req1 = 1'b0;
    if (lat != 99) begin
      check($sformatf("grant_on_ack_p%0d", p), {31'd0, grant}, {31'd0, p});
      model_last = p;
      if (w) ref_mem[a] = d;
    end
    repeat (2) @(negedge clock);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd_a, rd_b, hold_val, exp_v;
  int          lat_a, lat_b, base, snap;
  logic [9:0]  ra [0:3];
  logic [9:0]  wa [0:3];
  logic [31:0] wd [0:3];
  logic        first;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 0; mem[1] = 1; mem[2] = 1; mem[3] = 2;
    mem[4] = 3; mem[5] = 5; mem[6] = 8; mem[7] = 13;
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    model_last = 1'b1;
    reset_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (2) @(negedge clock);

    check("rst_ack", {30'd0, ack0, ack1}, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_ram_addr", {22'd0, ram_address}, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_ram_en", {30'd0, ram_wren, ram_wread}, 0);
    check("rst_busy_grant", {30'd0, busy, grant}, 0);
    check("rst_state", {30'd0, state_dbg}, 0);
    reset_n = 1;
    @(negedge clock);

    // Simultaneous first requests: port 0 wins the tie after reset.
    base = grant_log.size();
    fork
      req_port(0, 0, 10'd3, 0, rd_a, lat_a);
      req_port(1, 0, 10'd4, 0, rd_b, lat_b);
    join
    check("t2_lat0", lat_a, 2);
    check("t2_lat1", lat_b, 5);
    check("t2_rd0", rd_a, ref_mem[3]);
    check("t2_rd1", rd_b, ref_mem[4]);
    check("t2_order0", {31'd0, grant_log[base]}, 0);
    check("t2_order1", {31'd0, grant_log[base+1]}, 1);

    // Fibonacci preload read on port 1 via the expected queue.
    for (int i = 0; i < 8; i++) exp_q.push_back(ref_mem[i]);
    for (int i = 0; i < 8; i++) begin
      req_port(1, 0, 10'(i), 0, rd_b, lat_b);
      check("t4_lat", lat_b, 2);
      exp_v = exp_q.pop_front();
      check($sformatf("t4_rd%0d", i), rd_b, exp_v);
    end
    check("t4_rd_hold", rdata1, 32'd13);

    // Write then read on port 0; write must not touch rdata0.
    hold_val = rdata0;
    snap = wren_cycles;
    req_port(0, 1, 10'd5, 32'hDEADBEEF, rd_a, lat_a);
    check("t1_wr_lat", lat_a, 2);
    check("t1_wren_cycles", wren_cycles - snap, 1);
    check("t1_rdata_kept", rdata0, hold_val);
    req_port(0, 0, 10'd5, 0, rd_a, lat_a);
    check("t1_rd_lat", lat_a, 2);
    check("t1_rd", rd_a, 32'hDEADBEEF);

    // Continuous contention: port 0 reads, port 1 writes.
    for (int i = 0; i < 4; i++) begin
      ra[i] = 10'(100 + $urandom_range(0, 99));
      wa[i] = 10'(200 + i * 3 + $urandom_range(0, 2));
      wd[i] = $urandom;
    end
    hold_val = rdata1;
    first = ~model_last;
    base = grant_log.size();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          exp_v = ref_mem[ra[i]];
          req_port(0, 0, ra[i], 0, rd_a, lat_a);
          check("t3_rd0", rd_a, exp_v);
        end
      end
      begin
        for (int i = 0; i < 4; i++) begin
          req_port(1, 1, wa[i], wd[i], rd_b, lat_b);
          check("t3_wr_done", {31'd0, lat_b == 99}, 0);
          check("t3_rdata1_kept", rdata1, hold_val);
        end
      end
    join
    check("t3_log_len", grant_log.size() - base, 8);
    for (int i = 0; i < 8 && base + i < grant_log.size(); i++)
      check($sformatf("t3_alt%0d", i), {31'd0, grant_log[base+i]}, {31'd0, first ^ i[0]});
    for (int i = 0; i < 4; i++) begin
      req_port(0, 0, wa[i], 0, rd_a, lat_a);
      check("t3_readback", rd_a, ref_mem[wa[i]]);
    end

    // Reset in the middle of a write to addr 9.
    snap = ack_cnt;
    we0 = 1; addr0 = 10'd9; wdata0 = 32'h12345678; req0 = 1;
    @(negedge clock);
    check("t5_wren_in_access", {31'd0, ram_wren}, 1);
    reset_n = 0;
    #1;
    check("t5_wren_async", {31'd0, ram_wren}, 0);
    req0 = 0;
    repeat (3) @(negedge clock);
    reset_n = 1;
    model_last = 1'b1;
    check("t5_busy_grant", {30'd0, busy, grant}, 0);
    @(negedge clock);
    check("t5_no_ack", ack_cnt - snap, 0);
    req_port(0, 0, 10'd9, 0, rd_a, lat_a);
    check("t5_lat", lat_a, 2);
    check("t5_old_value", rd_a, ref_mem[9]);

    // Req held past the ack: a second access and one protocol flag.
    snap = proto_viol;
    we0 = 0; addr0 = 10'd5; req0 = 1; lat_a = 0;
    do begin @(negedge clock); lat_a++; end while (!ack0 && lat_a < 20);
    check("t6_first_lat", lat_a, 2);
    repeat (2) @(negedge clock);
    req0 = 0;
    lat_b = 2;
    while (!ack0 && lat_b < 20) begin @(negedge clock); lat_b++; end
    check("t6_second_ack_gap", lat_b, 3);
    check("t6_rd", rdata0, ref_mem[5]);
    check("t6_proto_flag", proto_viol - snap, 1);
    repeat (2) @(negedge clock);

    check("mon_enables", en_viol, 0);
    check("mon_ack_gap", gap_viol, 0);
    check("mon_proto_total", proto_viol, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
